axi_read_scheduler: RTL and testbench

Round-robin scheduler that shares the single AXI read channel (AR + R) among up to four cache-side read requesters (icache, dcache, uncached port, ...). It latches one winning request, drives the AR handshake, and steers R beats back to the owner. It also counts beats against the granted length and flags protocol errors. It sits between the cache controllers and the AXI read channels, beside the write-side logic.

---
 rtl/axi_read_scheduler.sv | 164 ++++++++++++++++
 tb/tb_axi_read_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_scheduler.sv
// Round-robin arbiter sharing one AXI read channel among N_REQ requesters.
// One burst outstanding at a time; R beats steered to the latched owner.
module axi_read_scheduler #(
  parameter int N_REQ = 3
) (
  input  logic                 clk,
  input  logic                 rset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_addr,
  input  logic [8*N_REQ-1:0]   req_len,
  input  logic [3*N_REQ-1:0]   req_size,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_last,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          axi_araddr,
  output logic [7:0]           axi_arlen,
  output logic [2:0]           axi_arsize,
  output logic [3:0]           axi_arid,
  output logic [1:0]           axi_arburst,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  input  logic [31:0]          axi_rdata,
  input  logic [3:0]           axi_rid,
  input  logic                 axi_rlast,
  input  logic [1:0]           axi_rresp,
  input  logic                 axi_rvalid,
  output logic                 axi_rready,
  output logic                 err_len,
  output logic                 err_resp,
  output logic                 busy
);

  localparam int OW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    r_state;
  logic [OW-1:0] r_rr_ptr;
  logic [OW-1:0] r_owner;
  logic [31:0]   r_araddr;
  logic [7:0]    r_arlen;
  logic [2:0]    r_arsize;
  logic          r_arvalid;
  logic [7:0]    r_beat_cnt;
  logic          r_resp_err;
  logic          r_err_len;
  logic          r_err_resp;

  logic          w_hit;
  logic [OW-1:0] w_pick;
  logic [31:0]   w_addr;
  logic [7:0]    w_len;
  logic [2:0]    w_size;
  logic [OW-1:0] w_next_ptr;
  logic [N_REQ-1:0] w_one;
  logic          w_ar_hs;
  logic          w_beat;
  logic          w_rresp_err;

  // Descending scan so the smallest offset from rr_ptr is assigned last.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = '0;
    w_addr = '0;
    w_len  = '0;
    w_size = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int s;
      s = int'(r_rr_ptr) + i;
      if (s >= N_REQ) s = s - N_REQ;
      if (req_valid[s]) begin
        w_hit  = 1'b1;
        w_pick = OW'(s);
        w_addr = req_addr[32*s +: 32];
        w_len  = req_len[8*s +: 8];
        w_size = req_size[3*s +: 3];
      end
    end
  end

  always_comb begin
    w_one = '0;
    w_one[r_owner] = 1'b1;
  end

  assign w_next_ptr = (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_ar_hs    = (r_state == S_ADDR) & r_arvalid & axi_arready;
  assign axi_rready = (r_state == S_DATA) & rsp_ready[r_owner];
  assign w_beat     = axi_rvalid & axi_rready;
  assign w_rresp_err = (axi_rresp != 2'b00);

  assign req_ready = w_ar_hs ? w_one : '0;
  assign rsp_valid = ((r_state == S_DATA) & axi_rvalid) ? w_one : '0;
  assign rsp_data  = axi_rdata;
  assign rsp_last  = axi_rlast;

  assign axi_araddr  = r_araddr;
  assign axi_arlen   = r_arlen;
  assign axi_arsize  = r_arsize;
  assign axi_arid    = {{(4-OW){1'b0}}, r_owner};
  assign axi_arburst = 2'b01;
  assign axi_arvalid = r_arvalid;
  assign err_len     = r_err_len;
  assign err_resp    = r_err_resp;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arsize   <= '0;
      r_arvalid  <= 1'b0;
      r_beat_cnt <= '0;
      r_resp_err <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_resp <= 1'b0;
    end else begin
      r_err_len  <= 1'b0;
      r_err_resp <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_owner   <= w_pick;
            r_araddr  <= w_addr;
            r_arlen   <= w_len;
            r_arsize  <= w_size;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_resp_err <= 1'b0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            if (r_beat_cnt != 8'hFF) r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_rresp_err) r_resp_err <= 1'b1;
            // Flags a missing rlast on the final beat or an early/late rlast.
            r_err_len <= (r_beat_cnt == r_arlen) ^ axi_rlast;
            if (axi_rlast) begin
              r_state    <= S_IDLE;
              r_rr_ptr   <= w_next_ptr;
              r_err_resp <= r_resp_err | w_rresp_err;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Directed testbench for axi_read_scheduler.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_read_scheduler;

  logic        clk;
  logic        rset;
  logic [2:0]  req_valid;
  logic [95:0] req_addr;
  logic [23:0] req_len;
  logic [8:0]  req_size;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic [2:0]  rsp_ready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [3:0]  axi_arid;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [3:0]  axi_rid;
  logic        axi_rlast;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        err_len;
  logic        err_resp;
  logic        busy;

  int n_vec;
  int n_err;

  axi_read_scheduler #(.N_REQ(3)) dut (
    .clk(clk), .rset(rset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arid(axi_arid),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid),
    .axi_rlast(axi_rlast), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .err_len(err_len), .err_resp(err_resp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic [31:0] a,
                         input logic [7:0] l);
    req_addr[32*k +: 32] = a;
    req_len[8*k +: 8]    = l;
    req_size[3*k +: 3]   = 3'd2;
  endtask

  task automatic beat(input logic [31:0] d, input logic last,
                      input logic [1:0] resp, input logic [2:0] own);
    axi_rvalid = 1'b1;
    axi_rdata  = d;
    axi_rlast  = last;
    axi_rresp  = resp;
    rsp_ready  = own;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(own));
    chk("rready", 64'(axi_rready), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(d));
    step();
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rresp  = 2'b00;
  endtask

  // Issue a single request from k with arready high; ends in DATA.
  task automatic grant(input int k, input logic [31:0] a,
                       input logic [7:0] l);
    logic [2:0] oh;
    oh = 3'b000;
    oh[k] = 1'b1;
    set_req(k, a, l);
    req_valid = oh;
    axi_arready = 1'b1;
    step();
    chk("g_arvalid", 64'(axi_arvalid), 64'd1);
    chk("g_arid", 64'(axi_arid), 64'(k));
    chk("g_araddr", 64'(axi_araddr), 64'(a));
    chk("g_req_ready", 64'(req_ready), 64'(oh));
    step();
    req_valid = 3'b000;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rset = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    req_size = '0;
    rsp_ready = '0;
    axi_arready = 1'b0;
    axi_rdata = '0;
    axi_rid = '0;
    axi_rlast = 1'b0;
    axi_rresp = '0;
    axi_rvalid = 1'b0;

    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
    chk("rst_araddr", 64'(axi_araddr), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rready", 64'(axi_rready), 64'd0);
    chk("rst_errs", 64'({err_len, err_resp}), 64'd0);
    rset = 1'b1;
    step();

    // Round robin from rr_ptr=0 with everyone requesting
    for (int k = 0; k < 3; k++) set_req(k, 32'h1000 * (k + 1), 8'd0);
    req_valid = 3'b111;
    axi_arready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      int e;
      e = g % 3;
      step();
      chk("rr_arid", 64'(axi_arid), 64'(e));
      chk("rr_araddr", 64'(axi_araddr), 64'(32'h1000 * (e + 1)));
      chk("rr_req_ready", 64'(req_ready), 64'(3'b001 << e));
      step();
      chk("rr_busy_data", 64'(busy), 64'd1);
      beat(32'hA000 + 32'(g), 1'b1, 2'b00, 3'b001 << e);
      chk("rr_idle_gap", 64'(busy), 64'd0);
      chk("rr_gap_arvalid", 64'(axi_arvalid), 64'd0);
      if (g == 5) req_valid = 3'b000;
    end

    // Single request with AR stall
    set_req(1, 32'h1FC0_0000, 8'd7);
    req_valid = 3'b010;
    axi_arready = 1'b0;
    step();
    chk("s_arvalid", 64'(axi_arvalid), 64'd1);
    chk("s_araddr", 64'(axi_araddr), 64'h1FC0_0000);
    chk("s_arlen", 64'(axi_arlen), 64'd7);
    chk("s_arid", 64'(axi_arid), 64'd1);
    chk("s_arsize", 64'(axi_arsize), 64'd2);
    chk("s_arburst", 64'(axi_arburst), 64'd1);
    chk("s_no_ready", 64'(req_ready), 64'd0);
    step();
    chk("s_hold_addr", 64'(axi_araddr), 64'h1FC0_0000);
    chk("s_hold_valid", 64'(axi_arvalid), 64'd1);
    axi_arready = 1'b1;
    #1;
    chk("s_req_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = 3'b000;
    chk("s_arvalid_clr", 64'(axi_arvalid), 64'd0);
    for (int b = 0; b < 8; b++) begin
      beat(32'hD000 + 32'(b), b == 7, 2'b00, 3'b010);
      chk("s_err_len", 64'(err_len), 64'd0);
      chk("s_err_resp", 64'(err_resp), 64'd0);
    end
    chk("s_idle", 64'(busy), 64'd0);

    // Backpressure: rr_ptr=2, only req0 valid, wraps to 0
    grant(0, 32'h0000_4000, 8'd3);
    beat(32'hB0, 1'b0, 2'b00, 3'b001);
    beat(32'hB1, 1'b0, 2'b00, 3'b001);
    axi_rvalid = 1'b1;
    axi_rdata = 32'hB2;
    rsp_ready = 3'b000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rready", 64'(axi_rready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'b001);
      chk("bp_data", 64'(rsp_data), 64'hB2);
      step();
      chk("bp_err_len", 64'(err_len), 64'd0);
    end
    beat(32'hB2, 1'b0, 2'b00, 3'b001);
    chk("bp_err_len2", 64'(err_len), 64'd0);
    beat(32'hB3, 1'b1, 2'b00, 3'b001);
    chk("bp_err_len_end", 64'(err_len), 64'd0);
    chk("bp_idle", 64'(busy), 64'd0);

    // Early rlast: len 3, rlast on third beat (rr_ptr=1 -> req2)
    grant(2, 32'h0000_5000, 8'd3);
    beat(32'hC0, 1'b0, 2'b00, 3'b100);
    beat(32'hC1, 1'b0, 2'b00, 3'b100);
    chk("el_pre", 64'(err_len), 64'd0);
    beat(32'hC2, 1'b1, 2'b00, 3'b100);
    chk("el_pulse", 64'(err_len), 64'd1);
    step();
    chk("el_once", 64'(err_len), 64'd0);
    chk("el_idle", 64'(busy), 64'd0);

    // Missing rlast: len 1, rlast only on fourth beat (rr_ptr=0 -> req0)
    grant(0, 32'h0000_6000, 8'd1);
    beat(32'hE0, 1'b0, 2'b00, 3'b001);
    chk("ml_pre", 64'(err_len), 64'd0);
    beat(32'hE1, 1'b0, 2'b00, 3'b001);
    chk("ml_pulse", 64'(err_len), 64'd1);
    chk("ml_busy", 64'(busy), 64'd1);
    beat(32'hE2, 1'b0, 2'b00, 3'b001);
    chk("ml_quiet", 64'(err_len), 64'd0);
    chk("ml_wait", 64'(busy), 64'd1);
    beat(32'hE3, 1'b1, 2'b00, 3'b001);
    chk("ml_late_last", 64'(err_len), 64'd1);
    chk("ml_idle", 64'(busy), 64'd0);

    // Resp error on beat 1 of 4 (rr_ptr=1 -> req1)
    grant(1, 32'h0000_7000, 8'd3);
    for (int b = 0; b < 4; b++) begin
      beat(32'hF0 + 32'(b), b == 3, (b == 1) ? 2'b10 : 2'b00, 3'b010);
      chk("re_err_resp", 64'(err_resp), (b == 3) ? 64'd1 : 64'd0);
      chk("re_err_len", 64'(err_len), 64'd0);
    end
    step();
    chk("re_once", 64'(err_resp), 64'd0);

    // Reset mid-burst (rr_ptr=2 -> req0)
    grant(0, 32'h0000_8000, 8'd3);
    beat(32'h90, 1'b0, 2'b00, 3'b001);
    beat(32'h91, 1'b0, 2'b00, 3'b001);
    axi_rvalid = 1'b1;
    rsp_ready = 3'b001;
    rset = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rready", 64'(axi_rready), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_araddr", 64'(axi_araddr), 64'd0);
    step();
    axi_rvalid = 1'b0;
    chk("mr_errs", 64'({err_len, err_resp}), 64'd0);
    rset = 1'b1;
    set_req(0, 32'h0000_A000, 8'd0);
    set_req(2, 32'h0000_C000, 8'd0);
    req_valid = 3'b101;
    step();
    chk("mr_first_arid", 64'(axi_arid), 64'd0);
    chk("mr_first_addr", 64'(axi_araddr), 64'h0000_A000);
    step();
    req_valid = 3'b000;
    beat(32'h55, 1'b1, 2'b00, 3'b001);
    chk("mr_post_errs", 64'({err_len, err_resp}), 64'd0);
    chk("mr_post_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
